// File: rtl/riscv_pc_alu_dmem.sv
// Execute/memory core: program counter, 32-bit ALU and word-addressed data memory.
// Latency: ALU result and load data are combinational; PC and stores update on the rising clk edge.
// Backpressure: none; every cycle advances the PC and stores are accepted whenever mem_write is high.
// Optional feature: define PC_BRANCH_EN to enable PC redirect via branch_take/branch_offset.
module riscv_pc_alu_dmem #(
  parameter int          DMEM_DEPTH = 256,
  parameter logic [31:0] PC_RESET   = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  alu_ctl,
  input  logic [31:0] alu_a,
  input  logic [31:0] alu_b,
  output logic [31:0] alu_out,
  output logic        zero,
  input  logic        mem_write,
  input  logic        mem_read,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  input  logic        branch_take,
  input  logic [31:0] branch_offset,
  output logic [31:0] pc_out
);

  localparam int AW = $clog2(DMEM_DEPTH);

  logic [31:0]   pc_q;
  logic [31:0]   pc_d;
  logic [31:0]   mem_q [DMEM_DEPTH];
  logic [AW-1:0] mem_idx;
  logic          unused_ok;

  // Byte address -> word index; low two bits and bits above the index are dropped,
  // so accesses are word aligned and wrap modulo the memory size.
  assign mem_idx = mem_addr[AW+1:2];

`ifdef PC_BRANCH_EN
  assign unused_ok = ^{mem_addr[31:AW+2], mem_addr[1:0]};

  // Next PC: taken branch adds the signed offset, otherwise fall through by one word.
  always_comb begin
    pc_d = pc_q + 32'd4;
    if (branch_take) pc_d = pc_q + branch_offset;
  end
`else
  assign unused_ok = ^{mem_addr[31:AW+2], mem_addr[1:0], branch_take, branch_offset};

  // Next PC: always the next sequential word.
  always_comb begin
    pc_d = pc_q + 32'd4;
  end
`endif

  // PC register; reset forces the fetch address back to PC_RESET asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc_q <= PC_RESET;
    else        pc_q <= pc_d;
  end

  assign pc_out = pc_q;

  // ALU operation decode; unassigned codes produce zero so the zero flag is set.
  always_comb begin
    alu_out = 32'd0;
    unique case (alu_ctl)
      4'd0:    alu_out = alu_a + alu_b;
      4'd8:    alu_out = alu_a - alu_b;
      4'd1:    alu_out = alu_a << alu_b[4:0];
      4'd5:    alu_out = alu_a >> alu_b[4:0];
      4'd13:   alu_out = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      4'd2:    alu_out = {31'd0, ($signed(alu_a) < $signed(alu_b))};
      4'd3:    alu_out = {31'd0, (alu_a < alu_b)};
      4'd4:    alu_out = alu_a ^ alu_b;
      4'd6:    alu_out = alu_a | alu_b;
      4'd7:    alu_out = alu_a & alu_b;
      default: alu_out = 32'd0;
    endcase
  end

  assign zero = (alu_out == 32'd0);

  // Store port; deliberately outside the reset domain so stores land even while reset is low
  // and the array contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_write) mem_q[mem_idx] <= mem_wdata;
  end

  // Load port reads the array asynchronously, so a same-cycle store is seen only after the edge.
  assign mem_rdata = mem_read ? mem_q[mem_idx] : 32'd0;

endmodule

// File: tb/tb_riscv_pc_alu_dmem.sv
// Directed bench for riscv_pc_alu_dmem: ALU vector table plus PC and memory sequences.
// Outputs are sampled away from the rising edge (negedge or #1 after a change).
// Build with PC_BRANCH_EN defined to exercise the branch path expectations.
module tb_riscv_pc_alu_dmem;

  localparam int DMEM_DEPTH = 256;

  logic        clk;
  logic        reset;
  logic [3:0]  alu_ctl;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_out;
  logic        zero;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        branch_take;
  logic [31:0] branch_offset;
  logic [31:0] pc_out;

  int checks   = 0;
  int failures = 0;

  riscv_pc_alu_dmem #(.DMEM_DEPTH(DMEM_DEPTH), .PC_RESET(32'h0)) dut (
    .clk           (clk),
    .reset         (reset),
    .alu_ctl       (alu_ctl),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_out       (alu_out),
    .zero          (zero),
    .mem_write     (mem_write),
    .mem_read      (mem_read),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .branch_take   (branch_take),
    .branch_offset (branch_offset),
    .pc_out        (pc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  ctl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } alu_vec_t;

  alu_vec_t vecs [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic mem_wr(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    mem_write = 1'b1;
    mem_addr  = addr;
    mem_wdata = data;
    @(negedge clk);
    mem_write = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] exp_br1;
    logic [31:0] exp_br2;

    vecs[0]  = '{4'd0,  32'd7,          32'd5,          32'd12};
    vecs[1]  = '{4'd8,  32'd7,          32'd5,          32'd2};
    vecs[2]  = '{4'd8,  32'd5,          32'd5,          32'd0};
    vecs[3]  = '{4'd0,  32'hFFFFFFFF,   32'd1,          32'd0};
    vecs[4]  = '{4'd2,  32'hFFFFFFF0,   32'd1,          32'd1};
    vecs[5]  = '{4'd3,  32'hFFFFFFF0,   32'd1,          32'd0};
    vecs[6]  = '{4'd2,  32'd1,          32'hFFFFFFF0,   32'd0};
    vecs[7]  = '{4'd3,  32'd1,          32'hFFFFFFF0,   32'd1};
    vecs[8]  = '{4'd13, 32'hFFFFFFF0,   32'd4,          32'hFFFFFFFF};
    vecs[9]  = '{4'd5,  32'hFFFFFFF0,   32'd4,          32'h0FFFFFFF};
    vecs[10] = '{4'd1,  32'd1,          32'd31,         32'h80000000};
    vecs[11] = '{4'd1,  32'd3,          32'h21,         32'd6};
    vecs[12] = '{4'd13, 32'h80000000,   32'd31,         32'hFFFFFFFF};
    vecs[13] = '{4'd4,  32'h0000F0F0,   32'h0000FF00,   32'h00000FF0};
    vecs[14] = '{4'd6,  32'h0000F0F0,   32'h0000FF00,   32'h0000FFF0};
    vecs[15] = '{4'd7,  32'h0000F0F0,   32'h0000FF00,   32'h0000F000};
    vecs[16] = '{4'd9,  32'd7,          32'd5,          32'd0};
    vecs[17] = '{4'd15, 32'd7,          32'd5,          32'd0};
    vecs[18] = '{4'd2,  32'd5,          32'd5,          32'd0};

    reset = 1'b0; alu_ctl = 4'd0; alu_a = 32'd0; alu_b = 32'd0;
    mem_write = 1'b0; mem_read = 1'b0; mem_addr = 32'd0; mem_wdata = 32'd0;
    branch_take = 1'b0; branch_offset = 32'd0;

    // PC reset and sequential advance
    #12;
    chk("pc_in_reset", pc_out, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1 chk("pc_after_release", pc_out, 32'd0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk($sformatf("pc_step%0d", i), pc_out, 32'(4 * i));
    end
    // asynchronous reset mid-cycle
    @(posedge clk);
    #2 reset = 1'b0;
    #1 chk("pc_async_reset", pc_out, 32'd0);
    @(negedge clk);
    chk("pc_held_in_reset", pc_out, 32'd0);
    reset = 1'b1;

    // branch redirect from PC=16
    repeat (4) @(negedge clk);
    chk("pc_before_branch", pc_out, 32'd16);
    branch_take   = 1'b1;
    branch_offset = 32'hFFFFFFF8;
`ifdef PC_BRANCH_EN
    exp_br1 = 32'd8;
    exp_br2 = 32'd12;
`else
    exp_br1 = 32'd20;
    exp_br2 = 32'd24;
`endif
    @(negedge clk);
    chk("pc_branch", pc_out, exp_br1);
    branch_take = 1'b0;
    @(negedge clk);
    chk("pc_after_branch", pc_out, exp_br2);

    // ALU table
    for (int i = 0; i < 19; i++) begin
      alu_ctl = vecs[i].ctl;
      alu_a   = vecs[i].a;
      alu_b   = vecs[i].b;
      #1;
      chk($sformatf("alu_out[%0d]", i), alu_out, vecs[i].exp);
      chk($sformatf("zero[%0d]", i), {31'd0, zero}, {31'd0, (vecs[i].exp == 32'd0)});
    end

    // data memory: store then load, byte-offset ignored, read enable gating
    mem_wr(32'd8, 32'hDEADBEEF);
    mem_read = 1'b1;
    mem_addr = 32'd8;
    #1 chk("ld_addr8", mem_rdata, 32'hDEADBEEF);
    mem_addr = 32'd11;
    #1 chk("ld_addr11", mem_rdata, 32'hDEADBEEF);
    mem_read = 1'b0;
    #1 chk("ld_rd_off", mem_rdata, 32'd0);

    // same-cycle read of a word being written returns the old value
    @(negedge clk);
    mem_read  = 1'b1;
    mem_write = 1'b1;
    mem_addr  = 32'd8;
    mem_wdata = 32'h11112222;
    #1 chk("ld_old_word", mem_rdata, 32'hDEADBEEF);
    @(negedge clk);
    mem_write = 1'b0;
    chk("ld_new_word", mem_rdata, 32'h11112222);

    // address wrap modulo DMEM_DEPTH*4
    mem_wr(32'd4, 32'h0BADF00D);
    mem_wr(32'(DMEM_DEPTH * 4 + 4), 32'h12345678);
    mem_addr = 32'd4;
    #1 chk("ld_wrap", mem_rdata, 32'h12345678);
    mem_addr = 32'd8;
    #1 chk("ld_wrap_neighbour", mem_rdata, 32'h11112222);

    // stores still land while reset is held low
    @(negedge clk);
    reset     = 1'b0;
    mem_write = 1'b1;
    mem_addr  = 32'd12;
    mem_wdata = 32'hA5A5C3C3;
    @(negedge clk);
    mem_write = 1'b0;
    chk("pc_reset_during_store", pc_out, 32'd0);
    reset = 1'b1;
    #1 chk("ld_store_in_reset", mem_rdata, 32'hA5A5C3C3);
    @(negedge clk);
    chk("pc_after_store_reset", pc_out, 32'd4);
    mem_read = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
